// File: rtl/assert_event_logger_pkg.sv
// Shared types for the assertion event logger: FSM state encoding and the
// {pass, id} entry stored in the event FIFO.
package assert_event_logger_pkg;

  localparam int EV_ID_W = 4;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_ON   = 2'd1,
    ST_KILL = 2'd2
  } state_t;

  typedef struct packed {
    logic               pass;
    logic [EV_ID_W-1:0] id;
  } ev_entry_t;

endpackage

// File: rtl/assert_event_fifo.sv
// Registered-output-free FIFO for logged events: storage, wrapping pointers
// and occupancy count; flush empties it in one cycle.
module assert_event_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/assert_event_logger.sv
// Assertion event logger: OFF/ON/KILL control FSM, saturating pass/fail
// counters, sticky overflow flag, and an in-order event FIFO.
module assert_event_logger
  import assert_event_logger_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ID_W  = EV_ID_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             kill,
  input  logic             ev_valid,
  input  logic             ev_pass,
  input  logic [ID_W-1:0]  ev_id,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ID_W:0]    out_data,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             overflow,
  output logic             state_on
);

  state_t      state;
  state_t      state_nxt;
  logic        logging;
  logic        log_ev;
  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  ev_entry_t   wr_entry;
  logic [ID_W:0] rd_word;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_OFF;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (kill) begin
      state_nxt = ST_KILL;
    end else begin
      case (state)
        ST_OFF:  if (en)  state_nxt = ST_ON;
        ST_ON:   if (!en) state_nxt = ST_OFF;
        ST_KILL: state_nxt = ST_OFF;
        default: state_nxt = ST_OFF;
      endcase
    end
  end

  always_comb begin
    state_on = (state == ST_ON);
    logging  = (state == ST_ON);
  end

  // A kill cycle discards both the incoming event and any pop.
  assign log_ev = logging && ev_valid && !kill;
  assign pop    = out_valid && out_ready && !kill;
  assign push   = log_ev && (!fifo_full || pop);

  assign wr_entry.pass = ev_pass;
  assign wr_entry.id   = ev_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      overflow <= 1'b0;
    end else if (kill) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      overflow <= 1'b0;
    end else if (log_ev) begin
      if (ev_pass) pass_cnt <= sat_inc(pass_cnt);
      else         fail_cnt <= sat_inc(fail_cnt);
      if (fifo_full && !pop) overflow <= 1'b1;
    end
  end

  assert_event_fifo #(
    .DEPTH (DEPTH),
    .W     (ID_W + 1)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (kill),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (rd_word),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = rd_word;

endmodule

// File: tb/tb_assert_event_logger.sv
// Scoreboarded bench for assert_event_logger: queue-based reference model,
// directed scenarios, randomized traffic and a mid-run reset.
module tb_assert_event_logger;

  localparam int DEPTH  = 8;
  localparam int CNTMAX = 255;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, kill, ev_valid, ev_pass, out_ready;
  logic [3:0] ev_id;
  logic       out_valid, overflow, state_on;
  logic [4:0] out_data;
  logic [7:0] pass_cnt, fail_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model: expected FIFO contents as a queue, plain counters.
  logic [4:0] exp_q[$];
  int  m_state;   // 0 = off, 1 = on, 2 = kill
  int  m_pass, m_fail;
  bit  m_ovf;

  always #5 clk = ~clk;

  assert_event_logger dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .kill      (kill),
    .ev_valid  (ev_valid),
    .ev_pass   (ev_pass),
    .ev_id     (ev_id),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .pass_cnt  (pass_cnt),
    .fail_cnt  (fail_cnt),
    .overflow  (overflow),
    .state_on  (state_on)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin : model
    bit popping;
    if (!rst_n) begin
      exp_q.delete();
      m_state <= 0;
      m_pass  <= 0;
      m_fail  <= 0;
      m_ovf   <= 1'b0;
    end else if (kill) begin
      exp_q.delete();
      m_state <= 2;
      m_pass  <= 0;
      m_fail  <= 0;
      m_ovf   <= 1'b0;
    end else begin
      popping = (exp_q.size() > 0) && out_ready;
      if (m_state == 1 && ev_valid) begin
        if (ev_pass) m_pass <= (m_pass < CNTMAX) ? m_pass + 1 : CNTMAX;
        else         m_fail <= (m_fail < CNTMAX) ? m_fail + 1 : CNTMAX;
        if (exp_q.size() < DEPTH || popping) exp_q.push_back({ev_pass, ev_id});
        else m_ovf <= 1'b1;
      end
      if (popping) void'(exp_q.pop_front());
      if (m_state == 2) m_state <= 0;
      else              m_state <= en ? 1 : 0;
    end
  end

  // Monitor: compares DUT outputs against the model away from the clock edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("mon_out_valid", out_valid, exp_q.size() != 0);
      if (out_valid && exp_q.size() != 0) chk("mon_out_data", out_data, exp_q[0]);
      chk("mon_pass_cnt", pass_cnt, m_pass);
      chk("mon_fail_cnt", fail_cnt, m_fail);
      chk("mon_overflow", overflow, m_ovf);
      chk("mon_state_on", state_on, m_state == 1);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send(input bit p, input int id);
    ev_valid = 1'b1;
    ev_pass  = p;
    ev_id    = 4'(id);
    step();
    ev_valid = 1'b0;
  endtask

  task automatic do_kill();
    kill = 1'b1;
    step();
    kill = 1'b0;
    chk("kill_out_valid", out_valid, 0);
    chk("kill_pass_cnt", pass_cnt, 0);
    chk("kill_fail_cnt", fail_cnt, 0);
    chk("kill_overflow", overflow, 0);
    chk("kill_state_on", state_on, 0);
    step();
    chk("after_kill_off", state_on, 0);
    step();
    chk("after_kill_on", state_on, en);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; en = 1'b0; kill = 1'b0; ev_valid = 1'b0;
    ev_pass = 1'b0; ev_id = '0; out_ready = 1'b0;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_pass_cnt", pass_cnt, 0);
    chk("rst_fail_cnt", fail_cnt, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_state_on", state_on, 0);
    step();
    rst_n = 1'b1;

    // Single pass event, latency one.
    en = 1'b1;
    step();
    chk("on_after_en", state_on, 1);
    send(1'b1, 3);
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 5'h13);
    chk("single_pass_cnt", pass_cnt, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("single_drained", out_valid, 0);

    // Nine fails into an eight-deep FIFO.
    for (int i = 0; i < 9; i++) send(1'b0, i);
    chk("ovf_fail_cnt", fail_cnt, 9);
    chk("ovf_flag", overflow, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ovf_order_valid", out_valid, 1);
      chk("ovf_order_data", out_data, i);
      step();
    end
    out_ready = 1'b0;
    chk("ovf_empty", out_valid, 0);

    // Kill with queued entries, counts and overflow set.
    for (int i = 0; i < 5; i++) send(1'b0, i);
    do_kill();

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 8; i++) send(1'b1, i);
    chk("full_no_ovf", overflow, 0);
    out_ready = 1'b1;
    send(1'b1, 8);
    out_ready = 1'b0;
    chk("pushpop_no_ovf", overflow, 0);
    chk("pushpop_head", out_data, 5'h11);
    out_ready = 1'b1;
    n = 0;
    while (out_valid && n < 20) begin
      step();
      n++;
    end
    out_ready = 1'b0;
    chk("pushpop_occupancy", n, 8);

    // Events while disabled are ignored; queued entries still drain.
    for (int i = 10; i < 14; i++) send(1'b0, i);
    en = 1'b0;
    step();
    for (int i = 0; i < 3; i++) send(1'b1, 1);
    chk("off_fail_cnt", fail_cnt, 4);
    chk("off_pass_cnt", pass_cnt, 9);
    out_ready = 1'b1;
    for (int i = 10; i < 14; i++) begin
      chk("off_drain_data", out_data, 16 + i - 16 + 0 * i);
      step();
    end
    out_ready = 1'b0;
    chk("off_drained", out_valid, 0);

    // Counter saturation.
    en = 1'b1;
    do_kill();
    out_ready = 1'b1;
    for (int i = 0; i < 255; i++) send(1'b1, i % 16);
    chk("sat_255", pass_cnt, 255);
    send(1'b1, 0);
    send(1'b1, 1);
    chk("sat_hold", pass_cnt, 255);
    step(2);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) en = ~en;
      kill      = ($urandom_range(0, 63) == 0);
      ev_valid  = $urandom_range(0, 1);
      ev_pass   = $urandom_range(0, 1);
      ev_id     = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) == 0);
      step();
    end
    kill = 1'b0; ev_valid = 1'b0;

    // Asynchronous reset in the middle of activity.
    en = 1'b1; out_ready = 1'b0;
    step(2);
    send(1'b0, 5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_fail", fail_cnt, 0);
    chk("mid_rst_state", state_on, 0);
    step();
    rst_n = 1'b1;
    ev_valid = 1'b1; ev_pass = 1'b1; ev_id = 4'd9;
    step();
    chk("post_rst_edge1_on", state_on, 1);
    chk("post_rst_edge1_empty", out_valid, 0);
    step();
    ev_valid = 1'b0;
    chk("post_rst_edge2_valid", out_valid, 1);
    chk("post_rst_edge2_data", out_data, 5'h19);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
